// File: rtl/uart_tx_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_mux: round-robin, message-granular arbiter for a shared UART TX   |
// | byte stream with optional "<id>:" prefix.          Rev 1.0                |
// +--------------------------------------------------------------------------+
module uart_tx_mux #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 1024,
  parameter bit PrefixEn      = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                out_valid_o,
  output logic [7:0]          out_data_o,
  input  logic                out_ready_i,
  output logic [NumReq-1:0]   grant_o,
  output logic                busy_o
);

  localparam int c_IDX_W = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int c_CNT_W = $clog2(TimeoutCycles);
  localparam logic [c_IDX_W-1:0] c_LAST_INIT = c_IDX_W'(NumReq - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PFX_ID    = 2'd1,
    S_PFX_COLON = 2'd2,
    S_STREAM    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [c_IDX_W-1:0]   owner_q, owner_d;
  logic [c_IDX_W-1:0]   last_q, last_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;

  logic                 w_win_found;
  logic [c_IDX_W-1:0]   w_win_idx;
  logic [c_IDX_W-1:0]   w_cand;
  logic                 w_owner_valid;
  logic [7:0]           w_owner_data;
  logic [7:0]           w_owner_ext;
  logic [7:0]           w_hex;
  logic [NumReq-1:0]    w_owner_oh;

  // Round-robin search beginning just after the previous winner.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int i = 1; i <= NumReq; i++) begin
      w_cand = c_IDX_W'((int'(last_q) + i) % NumReq);
      if (!w_win_found && req_valid_i[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_data  = 8'h00;
    for (int k = 0; k < NumReq; k++) begin
      if (owner_q == c_IDX_W'(k)) begin
        w_owner_valid = req_valid_i[k];
        w_owner_data  = req_data_i[8*k +: 8];
      end
    end
  end

  for (genvar k = 0; k < NumReq; k++) begin : g_owner_oh
    assign w_owner_oh[k] = (owner_q == c_IDX_W'(k));
  end

  assign w_owner_ext = 8'(owner_q);
  assign w_hex       = (w_owner_ext < 8'd10) ? (8'h30 + w_owner_ext) : (8'h37 + w_owner_ext);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_o = 1'b0;
    out_data_o  = 8'h00;
    req_ready_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (w_win_found) begin
          owner_d = w_win_idx;
          last_d  = w_win_idx;
          cnt_d   = '0;
          state_d = PrefixEn ? S_PFX_ID : S_STREAM;
        end
      end
      S_PFX_ID: begin
        out_valid_o = 1'b1;
        out_data_o  = w_hex;
        if (out_ready_i) state_d = S_PFX_COLON;
      end
      S_PFX_COLON: begin
        out_valid_o = 1'b1;
        out_data_o  = 8'h3A;
        if (out_ready_i) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end
      S_STREAM: begin
        out_valid_o = w_owner_valid;
        out_data_o  = w_owner_data;
        req_ready_o = w_owner_oh & {NumReq{out_ready_i}};
        // A valid-but-stalled owner leaves the idle counter untouched.
        if (w_owner_valid && out_ready_i) begin
          cnt_d = '0;
          if (w_owner_data == 8'h0A) state_d = S_IDLE;
        end else if (!w_owner_valid) begin
          if (cnt_q == c_CNT_MAX) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= c_LAST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign grant_o = busy_o ? w_owner_oh : '0;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_mux: directed self-checking bench for uart_tx_mux.             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_uart_tx_mux;

  logic clk;
  logic rst_a, rst_b;

  logic [3:0]   a_valid, a_rready, a_grant;
  logic [31:0]  a_data;
  logic         a_out_valid, a_oready, a_busy;
  logic [7:0]   a_out_data;

  logic [15:0]  b_valid, b_rready, b_grant;
  logic [127:0] b_data;
  logic         b_out_valid, b_oready, b_busy;
  logic [7:0]   b_out_data;

  uart_tx_mux #(.NumReq(4), .TimeoutCycles(8), .PrefixEn(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .req_valid_i(a_valid), .req_data_i(a_data), .req_ready_o(a_rready),
    .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_ready_i(a_oready),
    .grant_o(a_grant), .busy_o(a_busy)
  );

  uart_tx_mux #(.NumReq(16), .TimeoutCycles(4), .PrefixEn(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .req_valid_i(b_valid), .req_data_i(b_data), .req_ready_o(b_rready),
    .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_ready_i(b_oready),
    .grant_o(b_grant), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] msgq [4][$];
  logic [7:0] out_log[$];
  int         out_tk[$];
  int         tk = 0;
  bit         rnd_ready = 1'b0;
  bit         fix_ready = 1'b1;
  bit         stall_chk = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle of the requester/serializer model around DUT A.
  task automatic tick_a();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a_valid[k]       = (msgq[k].size() > 0);
      a_data[8*k +: 8] = a_valid[k] ? msgq[k][0] : 8'h00;
    end
    a_oready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
    #1;
    if (stall_chk && prev_stall) begin
      check_eq("stall_valid", a_out_valid, 1);
      check_eq("stall_data", a_out_data, prev_data);
    end
    prev_stall = a_out_valid && !a_oready;
    prev_data  = a_out_data;
    if (a_out_valid && a_oready) begin
      out_log.push_back(a_out_data);
      out_tk.push_back(tk);
    end
    for (int k = 0; k < 4; k++)
      if (a_valid[k] && a_rready[k]) void'(msgq[k].pop_front());
    tk++;
  endtask

  task automatic run_until_log(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (out_log.size() < n && c < budget) begin
      tick_a();
      c++;
    end
    check_eq(tag, out_log.size(), n);
  endtask

  task automatic clear_log();
    out_log.delete();
    out_tk.delete();
  endtask

  initial begin
    int ids[5];
    int hx, drop_tk, c;
    ids = '{0, 1, 2, 3, 0};
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = '0; a_data = '0; a_oready = 1'b1;
    b_valid = '0; b_data = '0; b_oready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_out_data", a_out_data, 8'h00);
    check_eq("rst_req_ready", a_rready, 0);
    check_eq("rst_grant", a_grant, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_b_grant", b_grant, 0);
    check_eq("rst_b_out_valid", b_out_valid, 0);

    // First grant and round-robin: 0,1,2,3 each "ab\n", then 0 again
    for (int k = 0; k < 4; k++) begin
      msgq[k].push_back(8'h61); msgq[k].push_back(8'h62); msgq[k].push_back(8'h0A);
    end
    msgq[0].push_back(8'h61); msgq[0].push_back(8'h62); msgq[0].push_back(8'h0A);
    rst_a = 1'b0; rst_b = 1'b0;
    tick_a();
    check_eq("idle_grant", a_grant, 0);
    check_eq("idle_out_valid", a_out_valid, 0);
    tick_a();
    check_eq("first_grant", a_grant, 4'b0001);
    check_eq("first_busy", a_busy, 1);
    run_until_log(25, 200, "rr_count");
    if (out_log.size() >= 25) begin
      for (int m = 0; m < 5; m++) begin
        check_eq("rr_id", out_log[m*5], 8'h30 + 8'(ids[m]));
        check_eq("rr_colon", out_log[m*5+1], 8'h3A);
        check_eq("rr_a", out_log[m*5+2], 8'h61);
        check_eq("rr_b", out_log[m*5+3], 8'h62);
        check_eq("rr_nl", out_log[m*5+4], 8'h0A);
      end
      for (int m = 0; m < 4; m++)
        check_eq("rr_bubble", out_tk[m*5+5] - out_tk[m*5+4], 2);
    end

    // Backpressure on requester 2
    clear_log();
    msgq[2].push_back(8'h41); msgq[2].push_back(8'h42); msgq[2].push_back(8'h0A);
    rnd_ready = 1'b1; stall_chk = 1'b1; prev_stall = 1'b0;
    run_until_log(5, 300, "bp_count");
    rnd_ready = 1'b0; stall_chk = 1'b0;
    repeat (5) tick_a();
    check_eq("bp_no_dup", out_log.size(), 5);
    if (out_log.size() >= 5) begin
      check_eq("bp_b0", out_log[0], 8'h32);
      check_eq("bp_b1", out_log[1], 8'h3A);
      check_eq("bp_b2", out_log[2], 8'h41);
      check_eq("bp_b3", out_log[3], 8'h42);
      check_eq("bp_b4", out_log[4], 8'h0A);
    end

    // Timeout: requester 1 sends 'x' then goes quiet, requester 3 waits
    clear_log();
    fix_ready = 1'b1;
    msgq[1].push_back(8'h78);
    run_until_log(3, 50, "to_count");
    check_eq("to_pfx", out_log[0], 8'h31);
    hx = out_tk[2];
    msgq[3].push_back(8'h71); msgq[3].push_back(8'h0A);
    c = 0;
    do begin
      tick_a();
      c++;
    end while (a_grant == 4'b0010 && c < 50);
    drop_tk = tk - 1;
    check_eq("to_drop_cycle", drop_tk - hx, 9);
    check_eq("to_drop_grant", a_grant, 0);
    tick_a();
    check_eq("to_next_grant", a_grant, 4'b1000);
    run_until_log(7, 50, "to_r3_count");
    if (out_log.size() >= 7) begin
      check_eq("to_r3_pfx", out_log[3], 8'h33);
      check_eq("to_r3_data", out_log[5], 8'h71);
    end

    // Long downstream stall must not time out the owner
    clear_log();
    msgq[0].push_back(8'h73); msgq[0].push_back(8'h0A);
    run_until_log(2, 50, "st_pfx_count");
    fix_ready = 1'b0;
    repeat (40) tick_a();
    check_eq("st_grant", a_grant, 4'b0001);
    check_eq("st_valid", a_out_valid, 1);
    check_eq("st_data", a_out_data, 8'h73);
    check_eq("st_no_xfer", out_log.size(), 2);
    fix_ready = 1'b1;
    run_until_log(4, 50, "st_count");
    if (out_log.size() >= 4) begin
      check_eq("st_b2", out_log[2], 8'h73);
      check_eq("st_b3", out_log[3], 8'h0A);
    end

    // DUT B: NumReq=16, no prefix, reset mid-message
    @(negedge clk);
    b_oready = 1'b1; b_valid = 16'h8000; b_data[127:120] = 8'h7A;
    #1;
    check_eq("b_idle_busy", b_busy, 0);
    @(negedge clk); #1;
    check_eq("b_grant15", b_grant, 16'h8000);
    check_eq("b_valid_z", b_out_valid, 1);
    check_eq("b_data_z", b_out_data, 8'h7A);
    check_eq("b_ready15", b_rready, 16'h8000);
    @(negedge clk);
    b_data[127:120] = 8'h0A;
    #1;
    check_eq("b_data_nl", b_out_data, 8'h0A);
    check_eq("b_valid_nl", b_out_valid, 1);
    @(negedge clk);
    b_valid = '0;
    #1;
    check_eq("b_release_busy", b_busy, 0);
    check_eq("b_release_valid", b_out_valid, 0);

    @(negedge clk);
    b_valid = 16'h8000; b_data[127:120] = 8'h7A; b_oready = 1'b0;
    @(negedge clk); #1;
    check_eq("b_mid_valid", b_out_valid, 1);
    rst_b = 1'b1;
    @(negedge clk); #1;
    check_eq("b_rst_valid", b_out_valid, 0);
    check_eq("b_rst_grant", b_grant, 0);
    check_eq("b_rst_busy", b_busy, 0);
    check_eq("b_rst_ready", b_rready, 0);
    rst_b = 1'b0; b_valid = 16'h8001; b_data[7:0] = 8'h55; b_oready = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_eq("b_after_rst_grant", b_grant, 16'h0001);
    check_eq("b_after_rst_data", b_out_data, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
